// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector with runtime-loadable pattern and overlap mode.
// Produces a registered one-cycle match flag, a saturating match counter and a history fill level.
module seq_detector_param #(
  parameter int                 PAT_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [PAT_W-1:0]   RST_PATTERN = PAT_W'(4'b1011),
  parameter bit                 RST_OVERLAP = 1'b1,
  localparam int                FILL_W      = $clog2(PAT_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              x,
  input  logic              in_valid,
  input  logic              cfg_load,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic              clear_count,
  output logic              y,
  output logic [CNT_W-1:0]  match_count,
  output logic [FILL_W-1:0] fill
);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  pattern;
  logic              overlap;

  logic [PAT_W-1:0]  hist_next;
  logic [FILL_W-1:0] fill_next;
  logic              accept;
  logic              match;

  // Candidate history/fill after an accepted bit; a match only counts once the window is entirely fresh.
  always_comb begin
    hist_next = {hist[PAT_W-2:0], x};
    fill_next = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
    accept    = in_valid && !cfg_load;
    match     = accept && (hist_next == pattern) && (fill_next == FILL_FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist        <= '0;
      fill        <= '0;
      pattern     <= RST_PATTERN;
      overlap     <= RST_OVERLAP;
      y           <= 1'b0;
      match_count <= '0;
    end else if (cfg_load) begin
      pattern     <= cfg_pattern;
      overlap     <= cfg_overlap;
      hist        <= '0;
      fill        <= '0;
      y           <= 1'b0;
      match_count <= '0;
    end else begin
      y <= match;
      if (accept) begin
        hist <= hist_next;
        // Non-overlapping mode forces the next match to be built from entirely new bits.
        if (match && !overlap)
          fill <= '0;
        else
          fill <= fill_next;
      end
      if (clear_count)
        match_count <= '0;
      else if (match && match_count != CNT_MAX)
        match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomised and directed bench for seq_detector_param; a queue-based reference model feeds
// a scoreboard that a separate monitor drains one cycle after each stimulus edge.
module tb_seq_detector_param;

  localparam int PAT_W   = 4;
  localparam int CNT_W   = 2;
  localparam int FILL_W  = $clog2(PAT_W + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [PAT_W-1:0] RST_PAT = 4'b1011;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              x = 1'b0;
  logic              in_valid = 1'b0;
  logic              cfg_load = 1'b0;
  logic [PAT_W-1:0]  cfg_pattern = '0;
  logic              cfg_overlap = 1'b0;
  logic              clear_count = 1'b0;
  logic              y;
  logic [CNT_W-1:0]  match_count;
  logic [FILL_W-1:0] fill;

  seq_detector_param #(
    .PAT_W(PAT_W), .CNT_W(CNT_W), .RST_PATTERN(RST_PAT), .RST_OVERLAP(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .clear_count(clear_count),
    .y(y), .match_count(match_count), .fill(fill)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y;
    int cnt;
    int fill;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  // Reference model: the freshly accepted bits (oldest first), never more than PAT_W of them.
  int               m_bits[$];
  logic [PAT_W-1:0] m_pat = RST_PAT;
  bit               m_ov  = 1'b1;
  int               m_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int window_value();
    int v = 0;
    foreach (m_bits[i]) v = (v << 1) | m_bits[i];
    return v;
  endfunction

  task automatic apply_stimulus(input bit xi, input bit vi, input bit ld,
                                input logic [PAT_W-1:0] pat, input bit ov, input bit clr);
    exp_t e;
    @(negedge clk);
    x = xi; in_valid = vi; cfg_load = ld; cfg_pattern = pat; cfg_overlap = ov; clear_count = clr;
    e.y = 0;
    if (ld) begin
      m_pat = pat; m_ov = ov; m_bits.delete(); m_cnt = 0;
    end else begin
      if (vi) begin
        m_bits.push_back(int'(xi));
        if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
        if (m_bits.size() == PAT_W && window_value() == int'(m_pat)) begin
          e.y = 1;
          if (m_cnt < CNT_MAX) m_cnt++;
          if (!m_ov) m_bits.delete();
        end
      end
      if (clr) m_cnt = 0;
    end
    e.cnt  = m_cnt;
    e.fill = m_bits.size();
    sb.push_back(e);
  endtask

  task automatic send_bit(input bit b);
    apply_stimulus(b, 1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic gap();
    apply_stimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic load_cfg(input logic [PAT_W-1:0] pat, input bit ov);
    apply_stimulus(1'b0, 1'b1, 1'b1, pat, ov, 1'b0);
  endtask

  task automatic send_stream(input logic [6:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge can intervene.
  task automatic pulse_reset();
    @(negedge clk);
    in_valid = 1'b0; cfg_load = 1'b0; clear_count = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("reset_y", int'(y), 0);
    check("reset_count", int'(match_count), 0);
    check("reset_fill", int'(fill), 0);
    m_bits.delete(); m_pat = RST_PAT; m_ov = 1'b1; m_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("y", int'(y), e.y);
        check("match_count", int'(match_count), e.cnt);
        check("fill", int'(fill), e.fill);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    #1 reset = 1'b1;
    #2;
    check("por_y", int'(y), 0);
    check("por_count", int'(match_count), 0);
    check("por_fill", int'(fill), 0);
    @(negedge clk);
    reset = 1'b0;

    // Overlapping: matches after bits 4 and 7.
    load_cfg(4'b1011, 1'b1);
    send_stream(7'b1011011, 7);
    gap();
    check("ovl_count", int'(match_count), 2);

    // Non-overlapping: one match, three fresh bits left over.
    load_cfg(4'b1011, 1'b0);
    send_stream(7'b1011011, 7);
    gap();
    check("novl_count", int'(match_count), 1);
    check("novl_fill", int'(fill), 3);

    // Gaps inside a sequence do not break it.
    load_cfg(4'b1011, 1'b1);
    send_bit(1'b1); send_bit(1'b0);
    gap(); gap(); gap();
    send_bit(1'b1); send_bit(1'b1);
    gap();
    check("gap_count", int'(match_count), 1);

    // Saturation then clear coinciding with the sixth match.
    load_cfg(4'b1011, 1'b1);
    send_stream(7'b0001011, 4);
    for (int i = 0; i < 4; i++) send_stream(7'b0000011, 3);
    send_bit(1'b0); send_bit(1'b1);
    apply_stimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    gap();
    check("sat_clear_count", int'(match_count), 0);

    // Reload mid-stream discards partial history.
    load_cfg(4'b1011, 1'b1);
    send_bit(1'b1); send_bit(1'b0);
    load_cfg(4'b0110, 1'b1);
    send_stream(7'b0000110, 4);
    gap();
    check("reload_count", int'(match_count), 1);

    // Reset between bits 3 and 4 leaves no match.
    load_cfg(4'b1011, 1'b1);
    send_stream(7'b0000101, 3);
    pulse_reset();
    send_bit(1'b1);
    gap();
    check("rst_mid_y", int'(y), 0);
    check("rst_mid_fill", int'(fill), 1);

    // Random traffic with occasional reconfiguration, clears and resets.
    for (int i = 0; i < 2500; i++) begin
      int r = int'($urandom_range(0, 999));
      if (r < 5) pulse_reset();
      else if (r < 20) load_cfg(PAT_W'($urandom), 1'($urandom));
      else
        apply_stimulus(1'($urandom), ($urandom_range(0, 3) != 0), 1'b0, '0, 1'b0,
                       ($urandom_range(0, 31) == 0));
    end
    gap();

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter PAT_W, default 4, pattern length in bits, legal range 2..16.
REQ-002 Parameter CNT_W, default 8, width of the match counter, legal range 1..16.
REQ-003 Parameter RST_PATTERN, default 4'b1011 (PAT_W bits), pattern value loaded by reset.
REQ-004 Parameter RST_OVERLAP, default 1, overlap mode loaded by reset (1 = overlapping, 0 = non-overlapping).
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 x  input  1  serial data bit.
REQ-008 in_valid  input  1  x is sampled only on edges where in_valid=1.
REQ-009 cfg_load  input  1  loads cfg_pattern and cfg_overlap when high.
REQ-010 cfg_pattern  input  PAT_W  new pattern; bit PAT_W-1 is the first (oldest) bit of the sequence.
REQ-011 cfg_overlap  input  1  new overlap mode.
REQ-012 clear_count  input  1  synchronous clear of match_count.
REQ-013 y  output  1  registered Moore match flag.
REQ-014 match_count  output  CNT_W  saturating count of matches.
REQ-015 fill  output  clog2(PAT_W+1)  number of valid history bits, 0..PAT_W.

Function
REQ-016 Internal state: history shift register hist[PAT_W-1:0], fill counter, pattern register, overlap register.
REQ-017 Accept edge (in_valid=1, cfg_load=0): hist <= {hist[PAT_W-2:0], x}; fill <= min(fill+1, PAT_W).
REQ-018 Match: true on an accept edge when the updated hist equals the pattern register and the updated fill equals PAT_W.
REQ-019 y SHALL be 1 for exactly the one cycle following a match edge and 0 otherwise, including cycles with in_valid=0.
REQ-020 Latency: y rises on the same rising edge that samples the final pattern bit; it is visible for the following cycle.
REQ-021 Overlapping mode: a match leaves hist and fill unchanged (fill stays PAT_W), so a suffix of one match can start the next.
REQ-022 Non-overlapping mode: a match sets fill <= 0, so the next match needs PAT_W freshly accepted bits.
REQ-023 Edges with in_valid=0 hold hist, fill, and match_count and set y <= 0; gaps do not break a sequence.
REQ-024 match_count increments by 1 on each match edge and saturates at 2^CNT_W-1 with no wrap.
REQ-025 cfg_load=1: pattern and overlap registers load; hist <= 0; fill <= 0; y <= 0; match_count <= 0; x is not sampled even if in_valid=1.
REQ-026 clear_count=1 sets match_count <= 0 and takes priority over a simultaneous increment; y still asserts on that match.
REQ-027 Priority: reset > cfg_load > clear_count/accept.

Reset
REQ-028 While reset=1 (asynchronous assert), y=0, match_count=0, fill=0, hist=0, pattern=RST_PATTERN, overlap=RST_OVERLAP.
REQ-029 Deassertion is synchronous to clk; the first edge after deassertion may accept a bit.
REQ-030 Reset asserted mid-sequence discards partial history; no y pulse results from pre-reset bits.

Verification
REQ-031 Overlap mode, pattern 1011, in_valid=1, x=1,0,1,1,0,1,1 -> y high after bits 4 and 7; match_count=2.
REQ-032 Non-overlap mode, same stream -> y high after bit 4 only; match_count=1; fill=3 at the end.
REQ-033 Pattern 1011 sent with in_valid=0 for 3 cycles between bits 2 and 3 -> single y pulse after bit 4; y=0 during the gap cycles.
REQ-034 CNT_W=2, overlap mode, 5 matches, then clear_count together with a 6th match -> count sequence 1,2,3,3,3 then 0; y pulses on all 6 matches.
REQ-035 cfg_load of pattern 0110 after bits 1,0 of a stream -> fill=0 and count=0; the next bits 0,1,1,0 -> one y pulse.
REQ-036 reset pulsed asynchronously between bits 3 and 4 of 1011, then stream resumes with bit 1 -> no y pulse; fill=1.
